// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives a single-outstanding
// instruction SRAM request and hands {pc, inst} to ID over valid/allowin.
module if_fetch_stage #(
  parameter int              PC_W     = 32,
  parameter int              INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h1c000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_allowin_i,
  output logic                   if_to_id_valid_o,
  output logic [PC_W+INST_W-1:0] pc_inst_obus,
  input  logic                   br_taken_i,
  input  logic [PC_W-1:0]        br_target_i,
  output logic                   inst_sram_req_o,
  output logic [PC_W-1:0]        inst_sram_addr_o,
  input  logic                   inst_sram_addr_ok_i,
  input  logic                   inst_sram_data_ok_i,
  input  logic [INST_W-1:0]      inst_sram_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [PC_W-1:0]   fetch_pc;
  logic              cancel;
  logic              buf_valid;
  logic [PC_W-1:0]   buf_pc;
  logic [INST_W-1:0] buf_inst;
  logic              fire;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (inst_sram_addr_ok_i) state_nxt = WAIT;
      end
      WAIT: begin
        if (inst_sram_data_ok_i) begin
          state_nxt = (cancel || br_taken_i) ? REQ : HOLD;
        end
      end
      HOLD: begin
        if (fire || br_taken_i) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A redirect masks the handoff in the same cycle it arrives.
  always_comb begin
    inst_sram_req_o  = (state == REQ);
    inst_sram_addr_o = fetch_pc;
    if_to_id_valid_o = buf_valid & ~br_taken_i;
    fire             = if_to_id_valid_o & id_allowin_i;
    pc_inst_obus     = {buf_pc, buf_inst};
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      fetch_pc  <= RESET_PC;
      cancel    <= 1'b0;
      buf_valid <= 1'b0;
      buf_pc    <= '0;
      buf_inst  <= '0;
    end else begin
      unique case (state)
        REQ: begin
          if (br_taken_i) begin
            fetch_pc <= br_target_i;
            if (inst_sram_addr_ok_i) cancel <= 1'b1;
          end
        end
        WAIT: begin
          if (inst_sram_data_ok_i) begin
            if (cancel || br_taken_i) begin
              cancel <= 1'b0;
              if (br_taken_i) fetch_pc <= br_target_i;
            end else begin
              buf_pc    <= fetch_pc;
              buf_inst  <= inst_sram_rdata_i;
              buf_valid <= 1'b1;
            end
          end else if (br_taken_i) begin
            cancel   <= 1'b1;
            fetch_pc <= br_target_i;
          end
        end
        HOLD: begin
          if (fire) begin
            buf_valid <= 1'b0;
            fetch_pc  <= fetch_pc + PC_W'(4);
          end else if (br_taken_i) begin
            buf_valid <= 1'b0;
            fetch_pc  <= br_target_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage. Owns the fetch PC and drives a one-outstanding-request instruction-SRAM interface.
- Presents {pc,inst} to the IF→ID pipeline register through the valid/allowin handshake (if_to_id_valid_o / id_allowin_i).
- Accepts a redirect (branch/jump) from downstream and squashes wrong-path fetches, including in-flight ones.

Parameters:
- RESET_PC, 32'h1c000000, first fetch address after reset
- PC_W, 32, PC width
- INST_W, 32, instruction width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-high (asserted = 1)
- id_allowin_i  in  1  ID can accept data this cycle
- if_to_id_valid_o  out  1  pc_inst_obus holds a valid instruction
- pc_inst_obus  out  PC_W+INST_W  {pc, inst}, pc in the upper bits
- br_taken_i  in  1  redirect pulse, one cycle
- br_target_i  in  PC_W  redirect target
- inst_sram_req_o  out  1  fetch request
- inst_sram_addr_o  out  PC_W  fetch address
- inst_sram_addr_ok_i  in  1  request accepted this cycle
- inst_sram_data_ok_i  in  1  read data returned this cycle
- inst_sram_rdata_i  in  INST_W  returned instruction

Behaviour:
- Reset (synchronous, rst_n = 1):
  - state = IDLE; fetch_pc = RESET_PC; cancel = 0; buf_valid = 0; buffered pc/inst = 0.
  - Outputs: if_to_id_valid_o = 0, pc_inst_obus = 0, inst_sram_req_o = 0.
- States: IDLE, REQ, WAIT, HOLD.
- Output equations:
  - inst_sram_req_o = (state == REQ).
  - inst_sram_addr_o = fetch_pc (registered).
  - if_to_id_valid_o = buf_valid & ~br_taken_i. A redirect masks the handoff combinationally.
  - fire = if_to_id_valid_o & id_allowin_i.
- IDLE → REQ unconditionally. This is the first cycle after reset release.
- REQ:
  - On addr_ok → WAIT.
  - On br_taken without addr_ok: fetch_pc ← br_target, stay in REQ. The new address appears next cycle.
  - On br_taken with addr_ok in the same cycle: the old request is in flight. Set cancel = 1, fetch_pc ← br_target, → WAIT.
- WAIT:
  - On data_ok with cancel = 0 and no br_taken: buffer {fetch_pc, rdata}, buf_valid ← 1, → HOLD.
  - On data_ok with cancel = 1 or br_taken: discard data, cancel ← 0, → REQ. If br_taken, fetch_pc ← br_target.
  - On br_taken without data_ok: cancel ← 1, fetch_pc ← br_target, stay in WAIT.
- HOLD:
  - On fire: buf_valid ← 0, fetch_pc ← fetch_pc + 4, → REQ.
  - On br_taken: buf_valid ← 0, fetch_pc ← br_target, → REQ. No handoff occurs.
  - Otherwise hold buffer and outputs unchanged (stall).
- pc_inst_obus is stable while if_to_id_valid_o = 1 and id_allowin_i = 0.
- fetch_pc + 4 wraps modulo 2^PC_W.
- Throughput: one instruction per 3 cycles minimum (addr_ok same cycle as req, data_ok the next cycle, ID allowin immediate).
- data_ok received in IDLE, REQ or HOLD is a stale response (e.g. after reset mid-operation) and is ignored.
- Reset asserted in any state returns to the reset values on the next edge. Any pending cancel is cleared.
- br_target_i is not checked for alignment; it is passed through.

Test Plan:
- Reset release, SRAM gives addr_ok with req and data_ok the next cycle, id_allowin = 1:
  - req at cycle 1, addr 1c000000.
  - valid with {1c000000, inst0} at cycle 3.
  - Next req at cycle 4 with addr 1c000004.
- HOLD with id_allowin = 0 for 5 cycles:
  - valid stays 1 and obus is constant.
  - No new req is issued.
  - When allowin rises, one fire occurs and the next addr = pc + 4.
- br_taken (target 1c000100) in WAIT, data_ok 2 cycles later:
  - Returned data is dropped and valid never rises.
  - Next req addr = 1c000100.
- br_taken together with addr_ok in REQ:
  - Cancel is set.
  - The following data_ok is discarded.
  - Next fetch is 1c000100.
- br_taken in HOLD with id_allowin = 1:
  - if_to_id_valid_o = 0 that cycle, so no fire.
  - Next req addr = target.
- fetch_pc = ffff_fffc, fire → next addr = 0000_0000. Reset mid-WAIT followed by a late data_ok → ignored, and fetch restarts at RESET_PC.
